demux_1x2_buf: RTL



---
 rtl/demux_1x2_buf.sv | 96 +++++++++
 1 files changed

// File: rtl/demux_1x2_buf.sv
// Buffered 1:2 stream demux: in_sel=1 steers to FIFO A, 0 to FIFO B; 1-cycle latency, no bypass.
// in_ready follows only the selected FIFO's fullness; optional pop counters under DEMUX_STATS_EN.
module demux_1x2_buf #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_sel,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [WIDTH-1:0]      a_data,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [WIDTH-1:0]      b_data,
  output logic [DEPTH_LOG2:0]   a_count,
  output logic [DEPTH_LOG2:0]   b_count
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0]           a_xfers,
  output logic [31:0]           b_xfers
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  // Index 1 is FIFO A and index 0 is FIFO B, so in_sel indexes directly.
  logic [1:0]                   push;
  logic [1:0]                   pop;
  logic [1:0]                   full;
  logic [1:0]                   vld;
  logic [1:0][WIDTH-1:0]        dat;
  logic [1:0][DEPTH_LOG2:0]     cnt;
  logic [1:0]                   rdy;

  assign full[1]  = (cnt[1] == FULL);
  assign full[0]  = (cnt[0] == FULL);
  assign vld[1]   = (cnt[1] != '0);
  assign vld[0]   = (cnt[0] != '0);
  assign in_ready = in_sel ? ~full[1] : ~full[0];
  assign push[1]  = in_valid & in_ready & in_sel;
  assign push[0]  = in_valid & in_ready & ~in_sel;
  assign rdy      = {a_ready, b_ready};
  assign pop      = vld & rdy;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [DEPTH_LOG2:0]   count;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push[g]) begin
          mem[tail] <= in_data;
          tail      <= tail + 1'b1;
        end
        if (pop[g]) head <= head + 1'b1;
        if (push[g] && !pop[g]) count <= count + 1'b1;
        else if (!push[g] && pop[g]) count <= count - 1'b1;
      end
    end

    assign dat[g] = mem[head];
    assign cnt[g] = count;
  end

  assign a_valid = vld[1];
  assign a_data  = dat[1];
  assign a_count = cnt[1];
  assign b_valid = vld[0];
  assign b_data  = dat[0];
  assign b_count = cnt[0];

`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_xfers <= '0;
      b_xfers <= '0;
    end else begin
      if (pop[1]) a_xfers <= a_xfers + 32'd1;
      if (pop[0]) b_xfers <= b_xfers + 32'd1;
    end
  end
`endif

endmodule
